// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl
// Pipeline hazard controller with a deferred branch redirect, event counters
// and a sticky stall watchdog.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl #(
  parameter int WDOG_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_mem,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic        wdog_o
);

  localparam int CW = $clog2(WDOG_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(WDOG_LIMIT);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     pend_tgt_q, pend_tgt_d;
  logic [31:0]     stall_cnt_q, stall_cnt_d;
  logic [31:0]     flush_cnt_q, flush_cnt_d;
  logic [CW-1:0]   consec_q, consec_d;
  logic            wdog_q, wdog_d;
  logic [5:0]      stall_req;

  always_comb begin
    if (stallreq_mem)     stall_req = 6'b011111;
    else if (stallreq_id) stall_req = 6'b001111;
    else if (stallreq_if) stall_req = 6'b000011;
    else                  stall_req = 6'b000000;
  end

  // Hazard/redirect decode; a pending branch waits only on the memory stall
  // because EX stays frozen and keeps presenting the same branch meanwhile.
  always_comb begin
    stall          = 6'b000000;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    state_d        = state_q;
    pend_tgt_d     = pend_tgt_q;
    if (!rst) begin
      stall = stall_req;
      if (state_q == ST_PEND) begin
        if (!stallreq_mem) begin
          stall          = 6'b000000;
          flush          = 1'b1;
          redirect_valid = 1'b1;
          redirect_pc    = pend_tgt_q;
          state_d        = ST_RUN;
        end
      end else if (branch_i) begin
        if (stall_req[4]) begin
          pend_tgt_d = branch_target_i;
          state_d    = ST_PEND;
        end else begin
          stall          = 6'b000000;
          flush          = 1'b1;
          redirect_valid = 1'b1;
          redirect_pc    = branch_target_i;
        end
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    consec_d    = consec_q;
    wdog_d      = wdog_q;
    if (stall != 6'b000000) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
      if (consec_q < LIMIT) consec_d = consec_q + 1'b1;
    end else begin
      consec_d = '0;
    end
    if (flush) flush_cnt_d = flush_cnt_q + 32'd1;
    if (consec_d == LIMIT) wdog_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pend_tgt_q  <= 32'h0;
      stall_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
      consec_q    <= '0;
      wdog_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_tgt_q  <= pend_tgt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      consec_q    <= consec_d;
      wdog_q      <= wdog_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign wdog_o    = wdog_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// tb_pipe_ctrl
// Directed bench for pipe_ctrl with a behavioural reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_if = 1'b0, stallreq_id = 1'b0, stallreq_mem = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;
  logic [5:0]  stall;
  logic        flush, redirect_valid, wdog_o;
  logic [31:0] redirect_pc, stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  pipe_ctrl #(.WDOG_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id), .stallreq_mem(stallreq_mem),
    .branch_i(branch_i), .branch_target_i(branch_target_i),
    .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .wdog_o(wdog_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending branch as a flag+address, counters as plain ints.
  bit          m_pend = 0;
  logic [31:0] m_tgt = 0;
  longint      m_scnt = 0, m_fcnt = 0;
  int          m_run = 0;
  bit          m_wdog = 0;

  always @(negedge clk) begin
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    e_stall = 6'd0; e_flush = 1'b0; e_pc = 32'h0;
    if (!rst) begin
      if (stallreq_mem)     e_stall = 6'b011111;
      else if (stallreq_id) e_stall = 6'b001111;
      else if (stallreq_if) e_stall = 6'b000011;
      if (m_pend && !stallreq_mem) begin
        e_stall = 6'd0; e_flush = 1'b1; e_pc = m_tgt;
      end else if (!m_pend && branch_i && !stallreq_mem) begin
        e_stall = 6'd0; e_flush = 1'b1; e_pc = branch_target_i;
      end
    end
    chk("stall", {26'd0, stall}, {26'd0, e_stall});
    chk("flush", {31'd0, flush}, {31'd0, e_flush});
    chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, e_flush});
    chk("redirect_pc", redirect_pc, e_pc);
    chk("stall_cnt", stall_cnt, m_scnt[31:0]);
    chk("flush_cnt", flush_cnt, m_fcnt[31:0]);
    chk("wdog_o", {31'd0, wdog_o}, {31'd0, m_wdog});
    if (rst) begin
      m_pend = 0; m_tgt = 0; m_scnt = 0; m_fcnt = 0; m_run = 0; m_wdog = 0;
    end else begin
      if (e_stall != 0) begin
        m_scnt = (m_scnt + 1) % 64'h1_0000_0000;
        m_run = (m_run < LIM) ? m_run + 1 : LIM;
      end else m_run = 0;
      if (m_run == LIM) m_wdog = 1;
      if (e_flush) m_fcnt = (m_fcnt + 1) % 64'h1_0000_0000;
      if (m_pend) begin
        if (!stallreq_mem) m_pend = 0;
      end else if (branch_i && stallreq_mem) begin
        m_pend = 1; m_tgt = branch_target_i;
      end
    end
  end

  task automatic tick(input logic r, input logic fi, input logic id, input logic mem,
                      input logic br, input logic [31:0] tgt);
    @(posedge clk); #1;
    rst = r; stallreq_if = fi; stallreq_id = id; stallreq_mem = mem;
    branch_i = br; branch_target_i = tgt;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  initial begin
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 1, 1, 1, 1, 32'hDEAD_BEEF);   // reset dominates all inputs
    mid();
    chk("rst_stall", {26'd0, stall}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_pc", redirect_pc, 32'd0);

    tick(1, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0); mid(); chk("id_stall1", {26'd0, stall}, 32'h0F);
    tick(0, 0, 1, 0, 0, 0); mid(); chk("id_stall2", {26'd0, stall}, 32'h0F);
    tick(0, 0, 0, 0, 0, 0); mid();
    chk("id_stall_cnt", stall_cnt, 32'd2);
    chk("id_flush_cnt", flush_cnt, 32'd0);

    tick(0, 1, 0, 1, 0, 0); mid(); chk("mem_prio", {26'd0, stall}, 32'h1F);
    tick(0, 1, 0, 0, 0, 0); mid(); chk("if_only", {26'd0, stall}, 32'h03);

    tick(1, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 1, 32'h0000_1000); mid();
    chk("br_flush", {31'd0, flush}, 32'd1);
    chk("br_pc", redirect_pc, 32'h0000_1000);
    chk("br_stall", {26'd0, stall}, 32'd0);
    tick(0, 0, 0, 0, 0, 0); mid();
    chk("br_flush_cnt", flush_cnt, 32'd1);
    chk("br_no_stall_cnt", stall_cnt, 32'd0);

    tick(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 1, 1, 32'h80); mid();
      chk("pend_stall", {26'd0, stall}, 32'h1F);
      chk("pend_noflush", {31'd0, flush}, 32'd0);
    end
    tick(0, 0, 0, 0, 1, 32'h80); mid();
    chk("pend_flush", {31'd0, flush}, 32'd1);
    chk("pend_pc", redirect_pc, 32'h80);
    tick(0, 0, 0, 0, 0, 0); mid();
    chk("pend_flush_cnt", flush_cnt, 32'd1);
    chk("pend_stall_cnt", stall_cnt, 32'd3);

    tick(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      tick(0, 1, 0, 0, 0, 0); mid();
      chk("wdog_ramp", {31'd0, wdog_o}, (i == 5) ? 32'd1 : 32'd0);
    end
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0); mid();
    chk("wdog_sticky", {31'd0, wdog_o}, 32'd1);
    tick(1, 0, 0, 0, 0, 0); tick(0, 0, 0, 0, 0, 0); mid();
    chk("wdog_clr", {31'd0, wdog_o}, 32'd0);

    tick(0, 0, 0, 1, 1, 32'h0000_4444);
    tick(0, 0, 0, 1, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0); mid();
    chk("rst_pend_flush", {31'd0, flush}, 32'd0);
    chk("rst_pend_rv", {31'd0, redirect_valid}, 32'd0);
    chk("rst_pend_scnt", stall_cnt, 32'd0);
    chk("rst_pend_fcnt", flush_cnt, 32'd0);
    tick(0, 0, 0, 0, 0, 0); mid();
    chk("rst_pend_late", {31'd0, flush}, 32'd0);

    tick(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
